// File: rtl/exec_trace_buffer.sv
// Execution trace FIFO: snapshots PC/IR/Res once per instruction (fetch-state entry) for later readback.
// Optional build macro TRACE_STACK_PTRS_EN widens each entry with the MSP/RSP stack pointers.
module exec_trace_buffer #(
  parameter int          DEPTH         = 16,
  parameter int          AW            = 4,
  parameter logic [4:0]  CAPTURE_STATE = 5'd0,
`ifdef TRACE_STACK_PTRS_EN
  localparam int         W             = 80
`else
  localparam int         W             = 48
`endif
) (
  input  logic          CLK,
  input  logic          CtrlRst,
  input  logic          TraceEn,
  input  logic [4:0]    CurrentState,
  input  logic [15:0]   PCIn,
  input  logic [15:0]   IRIn,
  input  logic [15:0]   ResIn,
  input  logic [15:0]   MSPIn,
  input  logic [15:0]   RSPIn,
  input  logic          RdReq,
  output logic          RdValid,
  output logic [W-1:0]  RdData,
  output logic [AW:0]   Count,
  output logic          Empty,
  output logic          Full,
  output logic          Overflow,
  input  logic          OvfClr
);

  // Read handshake: a pop is accepted when RdReq=1 and the FIFO is not empty.
  // RdValid pulses high for exactly one cycle, the cycle after the accepted pop,
  // with RdData holding that entry; RdData keeps its value while RdValid=0.

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          in_cap_q;

  logic          at_cap_state;
  logic          cap_evt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;
  logic [W-1:0]  entry;

`ifdef TRACE_STACK_PTRS_EN
  assign entry = {PCIn, IRIn, ResIn, MSPIn, RSPIn};
`else
  assign entry = {PCIn, IRIn, ResIn};
  logic unused_stack_ptrs;
  assign unused_stack_ptrs = ^{MSPIn, RSPIn};
`endif

  assign at_cap_state = (CurrentState == CAPTURE_STATE);
  // Rising-edge detect so a fetch state held for several cycles yields one entry.
  assign cap_evt      = TraceEn & at_cap_state & ~in_cap_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign pop   = RdReq & ~empty;
  // A pop in the same cycle frees the slot being written when full.
  assign wr    = cap_evt & (~full | pop);
  assign drop  = cap_evt & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d      = ovf_q;
    rd_valid_d = pop;
    rd_data_d  = rd_data_q;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (OvfClr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CtrlRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      in_cap_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      in_cap_q   <= at_cap_state;
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge CLK) begin
    if (!CtrlRst && wr) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  assign RdValid  = rd_valid_q;
  assign RdData   = rd_data_q;
  assign Count    = count_q;
  assign Empty    = empty;
  assign Full     = full;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Bench for exec_trace_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_exec_trace_buffer;

`ifdef TRACE_STACK_PTRS_EN
  localparam int W = 80;
`else
  localparam int W = 48;
`endif
  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam logic [4:0] CAP   = 5'd0;

  // clock / reset
  logic          CLK = 1'b0;
  logic          CtrlRst = 1'b1;
  logic          TraceEn = 1'b0;
  logic [4:0]    CurrentState = 5'd1;
  logic [15:0]   PCIn = '0, IRIn = '0, ResIn = '0, MSPIn = '0, RSPIn = '0;
  logic          RdReq = 1'b0;
  logic          OvfClr = 1'b0;
  logic          RdValid;
  logic [W-1:0]  RdData;
  logic [AW:0]   Count;
  logic          Empty, Full, Overflow;

  always #5 CLK = ~CLK;

  exec_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .CAPTURE_STATE(CAP)) dut (
    .CLK(CLK), .CtrlRst(CtrlRst), .TraceEn(TraceEn), .CurrentState(CurrentState),
    .PCIn(PCIn), .IRIn(IRIn), .ResIn(ResIn), .MSPIn(MSPIn), .RSPIn(RSPIn),
    .RdReq(RdReq), .RdValid(RdValid), .RdData(RdData), .Count(Count),
    .Empty(Empty), .Full(Full), .Overflow(Overflow), .OvfClr(OvfClr)
  );

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  bit           m_prev_cap;
  bit           m_ovf;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_entry();
`ifdef TRACE_STACK_PTRS_EN
    return {PCIn, IRIn, ResIn, MSPIn, RSPIn};
`else
    return {PCIn, IRIn, ResIn};
`endif
  endfunction

  // Applies the rules to the inputs present at the coming edge.
  task automatic model_edge();
    bit cap, pop, was_full;
    if (CtrlRst) begin
      exp_q.delete();
      m_prev_cap = 0;
      m_ovf      = 0;
      m_valid    = 0;
      m_data     = '0;
    end else begin
      cap        = TraceEn && (CurrentState == CAP) && !m_prev_cap;
      m_prev_cap = (CurrentState == CAP);
      was_full   = (exp_q.size() == DEPTH);
      pop        = RdReq && (exp_q.size() > 0);
      m_valid    = pop;
      if (pop) m_data = exp_q.pop_front();
      if (OvfClr) m_ovf = 0;
      if (cap) begin
        if (!was_full || pop) exp_q.push_back(mk_entry());
        else m_ovf = 1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check("count", 128'(Count), 128'(exp_q.size()));
    check("empty", 128'(Empty), 128'(exp_q.size() == 0));
    check("full", 128'(Full), 128'(exp_q.size() == DEPTH));
    check("overflow", 128'(Overflow), 128'(m_ovf));
    check("rdvalid", 128'(RdValid), 128'(m_valid));
    check("rddata", 128'(RdData), 128'(m_data));
  endtask

  // driver tasks
  task automatic capture(input logic [15:0] pc, input bit rd);
    CurrentState = CAP;
    PCIn  = pc;
    IRIn  = 16'($urandom);
    ResIn = 16'($urandom);
    MSPIn = 16'($urandom);
    RSPIn = 16'($urandom);
    RdReq = rd;
    step();
    CurrentState = 5'd1;
    RdReq = 1'b0;
    step();
  endtask

  task automatic pop_one(input string tag, input logic [15:0] exp_pc);
    RdReq = 1'b1;
    step();
    RdReq = 1'b0;
    check(tag, 128'(RdData[W-1 -: 16]), 128'(exp_pc));
  endtask

  task automatic do_reset(input int cycles);
    CtrlRst = 1'b1;
    repeat (cycles) step();
    CtrlRst = 1'b0;
  endtask

  initial begin
    TraceEn = 1'b1;
    // 1: reset
    do_reset(4);
    check("rst_count", 128'(Count), 128'd0);
    check("rst_rddata", 128'(RdData), 128'd0);

    // 2: edge capture, held state yields one entry
    CurrentState = CAP; PCIn = 16'h0010; IRIn = 16'h1234; ResIn = 16'h0005;
    MSPIn = 16'h7FFE; RSPIn = 16'h3FFE;
    repeat (3) step();
    CurrentState = 5'd1;
    step();
    check("t2_count", 128'(Count), 128'd1);
    RdReq = 1'b1;
    step();
    RdReq = 1'b0;
    check("t2_valid", 128'(RdValid), 128'd1);
    check("t2_data", 128'(RdData[W-1 -: 48]), 128'(48'h0010_1234_0005));
`ifdef TRACE_STACK_PTRS_EN
    // 7: stack pointers in the low 32 bits
    check("t7_sp", 128'(RdData[31:0]), 128'(32'h7FFE_3FFE));
`endif
    check("t2_empty", 128'(Empty), 128'd1);
    step();

    // 3: wrap, full, overflow
    for (int i = 0; i < 17; i++) capture(16'(i), 1'b0);
    check("t3_full", 128'(Full), 128'd1);
    check("t3_ovf", 128'(Overflow), 128'd1);
    OvfClr = 1'b1; step(); OvfClr = 1'b0;
    check("t3_ovfclr", 128'(Overflow), 128'd0);
    for (int i = 0; i < 16; i++) pop_one("t3_order", 16'(i));
    check("t3_empty", 128'(Empty), 128'd1);

    // 4: full with simultaneous pop and capture
    for (int i = 0; i < 16; i++) capture(16'(i), 1'b0);
    capture(16'h00AA, 1'b1);
    check("t4_count", 128'(Count), 128'd16);
    check("t4_ovf", 128'(Overflow), 128'd0);
    for (int i = 1; i < 16; i++) pop_one("t4_order", 16'(i));
    pop_one("t4_last", 16'h00AA);

    // 5: empty with simultaneous pop and capture
    capture(16'h0055, 1'b1);
    check("t5_valid", 128'(RdValid), 128'd0);
    check("t5_count", 128'(Count), 128'd1);
    pop_one("t5_data", 16'h0055);

    // 6: reset mid-operation with a pending read
    for (int i = 0; i < 5; i++) capture(16'(100 + i), 1'b0);
    RdReq = 1'b1;
    do_reset(1);
    RdReq = 1'b0;
    check("t6_count", 128'(Count), 128'd0);
    check("t6_valid", 128'(RdValid), 128'd0);
    step();

    // randomized traffic with fill-biased and drain-biased phases
    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < 250; c++) begin
        TraceEn = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 2) == 0)
          CurrentState = ($urandom_range(0, 2) == 0) ? CAP : 5'($urandom_range(1, 31));
        PCIn  = 16'($urandom);
        IRIn  = 16'($urandom);
        ResIn = 16'($urandom);
        MSPIn = 16'($urandom);
        RSPIn = 16'($urandom);
        RdReq   = (ph % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
        OvfClr  = ($urandom_range(0, 40) == 0);
        CtrlRst = ($urandom_range(0, 400) == 0);
        step();
      end
    end
    CtrlRst = 1'b0; RdReq = 1'b0; OvfClr = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
